int_sequencer: RTL and testbench

- Interrupt/reset sequencer for the cpu6502 core.
- Latches NMI edges and IRQ levels, and arbitrates reset > NMI > IRQ > software BRK at instruction boundaries.
- Drives the core's forced-BRK opcode substitution, PC-increment hold, stack-write inhibit, pushed B bit and vector low byte (FA/FC/FE).
- Sits beside the microcode block and supplies the controls that a hard-wired BRK vector cannot.

---
 rtl/int_sequencer.sv | 164 ++++++++++++++++
 tb/tb_int_sequencer.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/int_sequencer.sv
// Interrupt/reset sequencer for the cpu6502 core: arbitrates RESET > NMI > IRQ > BRK
// and supplies forced-BRK, PC hold, stack-write inhibit, pushed B bit and vector low byte.
`timescale 1ns/1ps
module int_sequencer #(
   parameter logic [7:0] VEC_NMI = 8'hFA,
   parameter logic [7:0] VEC_RES = 8'hFC,
   parameter logic [7:0] VEC_IRQ = 8'hFE
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       ready,
   input  logic       nmi,
   input  logic       irq,
   input  logic       i_flag,
   input  logic       poll,
   input  logic       sync,
   input  logic [7:0] opcode,
   input  logic       vec_lock,
   input  logic       vec_done,
   output logic       force_brk,
   output logic       pc_hold,
   output logic       write_inhibit,
   output logic       b_flag,
   output logic [7:0] vector_lo,
   output logic       int_active,
   output logic       nmi_pending
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_RESET,
      S_NMI,
      S_IRQ,
      S_BRK
   } state_e;

   state_e     state_q;
   logic       nmi_prev_q;
   logic       nmi_pending_q;
   logic       nmi_pending_d;
   logic       locked_q;
   logic       hold2_q;
   logic       force_brk_q;
   logic       pc_hold_q;
   logic       write_inhibit_q;
   logic       b_flag_q;
   logic       int_active_q;
   logic [7:0] vector_lo_q;

   logic       nmi_edge;
   logic       irq_ok;
   logic       hijack;
   logic       nmi_clr;

   assign nmi_edge = nmi & ~nmi_prev_q;
   assign irq_ok   = irq & ~i_flag;
   assign hijack   = ((state_q == S_IRQ) | (state_q == S_BRK))
                     & nmi_pending_q & ~locked_q;
   assign nmi_clr  = ready & vec_lock & ~vec_done & ~locked_q
                     & ((state_q == S_NMI) | hijack);

   // A new edge wins over the service clear in the same cycle.
   always_comb begin
      nmi_pending_d = nmi_pending_q;
      if (nmi_clr) begin
         nmi_pending_d = 1'b0;
      end
      if (nmi_edge) begin
         nmi_pending_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         nmi_prev_q    <= 1'b0;
         nmi_pending_q <= 1'b0;
      end else begin
         nmi_prev_q    <= nmi;
         nmi_pending_q <= nmi_pending_d;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q         <= S_RESET;
         force_brk_q     <= 1'b1;
         pc_hold_q       <= 1'b1;
         write_inhibit_q <= 1'b1;
         b_flag_q        <= 1'b0;
         vector_lo_q     <= VEC_RES;
         int_active_q    <= 1'b1;
         locked_q        <= 1'b0;
         hold2_q         <= 1'b0;
      end else if (ready) begin
         unique case (state_q)
            S_IDLE: begin
               if (poll && (nmi_pending_q || irq_ok)) begin
                  if (nmi_pending_q) begin
                     state_q     <= S_NMI;
                     vector_lo_q <= VEC_NMI;
                  end else begin
                     state_q     <= S_IRQ;
                     vector_lo_q <= VEC_IRQ;
                  end
                  force_brk_q  <= 1'b1;
                  pc_hold_q    <= 1'b1;
                  b_flag_q     <= 1'b0;
                  int_active_q <= 1'b1;
                  locked_q     <= 1'b0;
                  hold2_q      <= 1'b0;
               end else if (sync && opcode == 8'h00 && !force_brk_q) begin
                  state_q      <= S_BRK;
                  vector_lo_q  <= VEC_IRQ;
                  force_brk_q  <= 1'b0;
                  pc_hold_q    <= 1'b0;
                  b_flag_q     <= 1'b1;
                  int_active_q <= 1'b1;
                  locked_q     <= 1'b0;
                  hold2_q      <= 1'b0;
               end
            end
            default: begin
               // pc_hold spans the forced sync cycle plus one more.
               if (sync && force_brk_q) begin
                  force_brk_q <= 1'b0;
                  hold2_q     <= 1'b1;
               end
               if (hold2_q) begin
                  pc_hold_q <= 1'b0;
                  hold2_q   <= 1'b0;
               end
               if (vec_done) begin
                  state_q         <= S_IDLE;
                  force_brk_q     <= 1'b0;
                  pc_hold_q       <= 1'b0;
                  write_inhibit_q <= 1'b0;
                  b_flag_q        <= 1'b0;
                  vector_lo_q     <= VEC_IRQ;
                  int_active_q    <= 1'b0;
                  locked_q        <= 1'b0;
                  hold2_q         <= 1'b0;
               end else if (!locked_q) begin
                  if (hijack) begin
                     state_q     <= S_NMI;
                     vector_lo_q <= VEC_NMI;
                  end
                  if (vec_lock) begin
                     locked_q <= 1'b1;
                  end
               end
            end
         endcase
      end
   end

   assign force_brk     = force_brk_q;
   assign pc_hold       = pc_hold_q;
   assign write_inhibit = write_inhibit_q;
   assign b_flag        = b_flag_q;
   assign vector_lo     = vector_lo_q;
   assign int_active    = int_active_q;
   assign nmi_pending   = nmi_pending_q;

endmodule

// File: tb/tb_int_sequencer.sv
// Bench for int_sequencer: sequence-level reference model checked every cycle,
// plus literal expectations at the key points of each directed scenario.
`timescale 1ns/1ps
module tb_int_sequencer;

   logic       clk = 1'b0;
   logic       reset_n = 1'b1;
   logic       ready = 1'b1;
   logic       nmi = 1'b0;
   logic       irq = 1'b0;
   logic       i_flag = 1'b1;
   logic       poll = 1'b0;
   logic       sync = 1'b0;
   logic [7:0] opcode = 8'hEA;
   logic       vec_lock = 1'b0;
   logic       vec_done = 1'b0;
   logic       force_brk;
   logic       pc_hold;
   logic       write_inhibit;
   logic       b_flag;
   logic [7:0] vector_lo;
   logic       int_active;
   logic       nmi_pending;

   int errors = 0;
   int checks = 0;
   bit chk_en = 1'b0;

   int_sequencer dut (
      .clk(clk),
      .reset_n(reset_n),
      .ready(ready),
      .nmi(nmi),
      .irq(irq),
      .i_flag(i_flag),
      .poll(poll),
      .sync(sync),
      .opcode(opcode),
      .vec_lock(vec_lock),
      .vec_done(vec_done),
      .force_brk(force_brk),
      .pc_hold(pc_hold),
      .write_inhibit(write_inhibit),
      .b_flag(b_flag),
      .vector_lo(vector_lo),
      .int_active(int_active),
      .nmi_pending(nmi_pending)
   );

   always #5 clk = ~clk;

   // Reference model: which sequence is running, and how far it has got.
   localparam int K_IDLE = 0;
   localparam int K_RES  = 1;
   localparam int K_NMI  = 2;
   localparam int K_IRQ  = 3;
   localparam int K_BRK  = 4;

   int m_kind = K_RES;
   int m_syncs = 0;
   bit m_pend = 1'b0;
   bit m_prev = 1'b0;
   bit m_forced = 1'b1;
   bit m_locked = 1'b0;
   bit m_b = 1'b0;

   always @(posedge clk or negedge reset_n) begin
      bit nedge;
      bit clr;
      if (!reset_n) begin
         m_kind = K_RES;
         m_syncs = 0;
         m_pend = 1'b0;
         m_prev = 1'b0;
         m_forced = 1'b1;
         m_locked = 1'b0;
         m_b = 1'b0;
      end else begin
         nedge = nmi && !m_prev;
         m_prev = nmi;
         clr = 1'b0;
         if (ready) begin
            if (m_kind == K_IDLE) begin
               if (poll && (m_pend || (irq && !i_flag))) begin
                  m_kind = m_pend ? K_NMI : K_IRQ;
                  m_forced = 1'b1;
                  m_b = 1'b0;
                  m_syncs = 0;
                  m_locked = 1'b0;
               end else if (sync && opcode == 8'h00) begin
                  m_kind = K_BRK;
                  m_forced = 1'b0;
                  m_b = 1'b1;
                  m_syncs = 0;
                  m_locked = 1'b0;
               end
            end else begin
               if (m_syncs > 0) begin
                  m_syncs = (m_syncs < 2) ? m_syncs + 1 : 2;
               end else if (sync && m_forced) begin
                  m_syncs = 1;
               end
               if (vec_done) begin
                  m_kind = K_IDLE;
                  m_forced = 1'b0;
                  m_b = 1'b0;
               end else if (!m_locked) begin
                  if ((m_kind == K_IRQ || m_kind == K_BRK) && m_pend) begin
                     m_kind = K_NMI;
                  end
                  if (vec_lock) begin
                     m_locked = 1'b1;
                     clr = (m_kind == K_NMI);
                  end
               end
            end
         end
         if (nedge) begin
            m_pend = 1'b1;
         end else if (clr) begin
            m_pend = 1'b0;
         end
      end
   end

   function automatic logic [7:0] exp_vec(input int k);
      case (k)
         K_RES:   return 8'hFC;
         K_NMI:   return 8'hFA;
         default: return 8'hFE;
      endcase
   endfunction

   task automatic cmp(input string n, input logic [7:0] act,
                      input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         cmp("force_brk", {7'd0, force_brk},
             {7'd0, m_forced && m_syncs == 0});
         cmp("pc_hold", {7'd0, pc_hold}, {7'd0, m_forced && m_syncs < 2});
         cmp("write_inhibit", {7'd0, write_inhibit},
             {7'd0, m_kind == K_RES});
         cmp("b_flag", {7'd0, b_flag}, {7'd0, m_b});
         cmp("vector_lo", vector_lo, exp_vec(m_kind));
         cmp("int_active", {7'd0, int_active}, {7'd0, m_kind != K_IDLE});
         cmp("nmi_pending", {7'd0, nmi_pending}, {7'd0, m_pend});
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic lit(input string n, input logic [7:0] act,
                      input logic [7:0] exp);
      cmp({"lit_", n}, act, exp);
   endtask

   initial begin
      #2 reset_n = 1'b0;
      #1 chk_en = 1'b1;
      repeat (3) tick();
      reset_n = 1'b1;
      lit("rst_vec", vector_lo, 8'hFC);
      lit("rst_wi", {7'd0, write_inhibit}, 8'd1);
      lit("rst_force", {7'd0, force_brk}, 8'd1);
      lit("rst_pend", {7'd0, nmi_pending}, 8'd0);
      tick();
      vec_lock = 1'b1; tick(); vec_lock = 1'b0;
      lit("rst_lock_vec", vector_lo, 8'hFC);
      vec_done = 1'b1; tick(); vec_done = 1'b0;
      lit("rst_idle_force", {7'd0, force_brk}, 8'd0);
      lit("rst_idle_wi", {7'd0, write_inhibit}, 8'd0);
      lit("rst_idle_act", {7'd0, int_active}, 8'd0);

      // IRQ masked, then unmasked
      irq = 1'b1; i_flag = 1'b1;
      poll = 1'b1; tick(); poll = 1'b0;
      lit("irq_masked", {7'd0, force_brk}, 8'd0);
      tick();
      i_flag = 1'b0;
      poll = 1'b1; tick(); poll = 1'b0; irq = 1'b0;
      lit("irq_force", {7'd0, force_brk}, 8'd1);
      lit("irq_vec", vector_lo, 8'hFE);
      lit("irq_b", {7'd0, b_flag}, 8'd0);
      sync = 1'b1; tick(); sync = 1'b0;
      lit("irq_hold2", {7'd0, pc_hold}, 8'd1);
      lit("irq_force_off", {7'd0, force_brk}, 8'd0);
      tick();
      lit("irq_hold_off", {7'd0, pc_hold}, 8'd0);
      vec_lock = 1'b1; tick(); vec_lock = 1'b0;
      vec_done = 1'b1; tick(); vec_done = 1'b0;

      // NMI pulse
      nmi = 1'b1; tick(); nmi = 1'b0;
      lit("nmi_pend", {7'd0, nmi_pending}, 8'd1);
      tick(); tick();
      poll = 1'b1; tick(); poll = 1'b0;
      lit("nmi_vec", vector_lo, 8'hFA);
      sync = 1'b1; tick(); sync = 1'b0;
      tick();
      vec_lock = 1'b1; tick(); vec_lock = 1'b0;
      lit("nmi_pend_clr", {7'd0, nmi_pending}, 8'd0);
      vec_done = 1'b1; tick(); vec_done = 1'b0;

      // NMI held high: only one sequence
      nmi = 1'b1; tick();
      poll = 1'b1; tick(); poll = 1'b0;
      sync = 1'b1; tick(); sync = 1'b0;
      vec_lock = 1'b1; tick(); vec_lock = 1'b0;
      vec_done = 1'b1; tick(); vec_done = 1'b0;
      poll = 1'b1; tick(); poll = 1'b0;
      lit("nmi_held_once", {7'd0, int_active}, 8'd0);
      nmi = 1'b0; tick();

      // Software BRK
      sync = 1'b1; opcode = 8'h00; tick(); sync = 1'b0; opcode = 8'hEA;
      lit("brk_b", {7'd0, b_flag}, 8'd1);
      lit("brk_vec", vector_lo, 8'hFE);
      lit("brk_hold", {7'd0, pc_hold}, 8'd0);
      tick(); tick();
      vec_lock = 1'b1; tick(); vec_lock = 1'b0;
      vec_done = 1'b1; tick(); vec_done = 1'b0;

      // Hijack of IRQ before vec_lock
      irq = 1'b1; poll = 1'b1; tick(); poll = 1'b0; irq = 1'b0;
      sync = 1'b1; tick(); sync = 1'b0;
      nmi = 1'b1; tick(); nmi = 1'b0;
      tick();
      lit("hij_vec", vector_lo, 8'hFA);
      lit("hij_b", {7'd0, b_flag}, 8'd0);
      vec_lock = 1'b1; tick(); vec_lock = 1'b0;
      lit("hij_pend", {7'd0, nmi_pending}, 8'd0);
      vec_done = 1'b1; tick(); vec_done = 1'b0;

      // Hijack of BRK keeps B=1
      sync = 1'b1; opcode = 8'h00; tick(); sync = 1'b0; opcode = 8'hEA;
      nmi = 1'b1; tick(); nmi = 1'b0;
      tick();
      lit("hijb_vec", vector_lo, 8'hFA);
      lit("hijb_b", {7'd0, b_flag}, 8'd1);
      vec_lock = 1'b1; tick(); vec_lock = 1'b0;
      vec_done = 1'b1; tick(); vec_done = 1'b0;

      // NMI edge after vec_lock: no hijack
      irq = 1'b1; poll = 1'b1; tick(); poll = 1'b0; irq = 1'b0;
      sync = 1'b1; tick(); sync = 1'b0;
      tick();
      vec_lock = 1'b1; tick(); vec_lock = 1'b0;
      nmi = 1'b1; tick(); nmi = 1'b0;
      lit("late_vec", vector_lo, 8'hFE);
      lit("late_pend", {7'd0, nmi_pending}, 8'd1);
      vec_done = 1'b1; tick(); vec_done = 1'b0;
      lit("late_pend_idle", {7'd0, nmi_pending}, 8'd1);
      poll = 1'b1; tick(); poll = 1'b0;
      lit("late_serv_vec", vector_lo, 8'hFA);
      sync = 1'b1; tick(); sync = 1'b0;
      vec_lock = 1'b1; tick(); vec_lock = 1'b0;
      vec_done = 1'b1; tick(); vec_done = 1'b0;

      // Ready stall across poll, sync and vec_lock
      irq = 1'b1; ready = 1'b0;
      poll = 1'b1; tick(); tick();
      lit("stall_idle", {7'd0, int_active}, 8'd0);
      ready = 1'b1; poll = 1'b0; tick();
      lit("stall_nopoll", {7'd0, int_active}, 8'd0);
      poll = 1'b1; tick(); poll = 1'b0; irq = 1'b0;
      lit("stall_go", {7'd0, force_brk}, 8'd1);
      ready = 1'b0; sync = 1'b1; tick();
      lit("stall_sync_held", {7'd0, force_brk}, 8'd1);
      ready = 1'b1; tick(); sync = 1'b0;
      lit("stall_sync_done", {7'd0, force_brk}, 8'd0);
      ready = 1'b0; vec_lock = 1'b1; vec_done = 1'b1; tick();
      lit("stall_done_held", {7'd0, int_active}, 8'd1);
      ready = 1'b1; vec_done = 1'b0; tick(); vec_lock = 1'b0;
      vec_done = 1'b1; tick(); vec_done = 1'b0;

      // Reset abort mid-NMI
      nmi = 1'b1; tick(); nmi = 1'b0;
      poll = 1'b1; tick(); poll = 1'b0;
      sync = 1'b1; tick(); sync = 1'b0;
      reset_n = 1'b0;
      #1;
      lit("abort_vec", vector_lo, 8'hFC);
      lit("abort_pend", {7'd0, nmi_pending}, 8'd0);
      lit("abort_wi", {7'd0, write_inhibit}, 8'd1);
      tick(); tick();
      reset_n = 1'b1;
      tick();
      vec_lock = 1'b1; tick(); vec_lock = 1'b0;
      vec_done = 1'b1; tick(); vec_done = 1'b0;
      lit("abort_idle", {7'd0, int_active}, 8'd0);
      tick(); tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
